hazard_stall_unit: RTL and testbench

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_stall_unit.sv | 111 +++++++++++
 tb/tb_hazard_stall_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller: load-use stalls, taken-branch flushes
// and multi-cycle divide freezes, plus a saturating stall-cycle counter.
module hazard_stall_unit #(
  parameter int DIV_CYCLES = 8,   // total EX cycles of a divide, 2..32
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,        // async, active low
  input  logic             MemRead_EX,
  input  logic [4:0]       RT_EX,
  input  logic [4:0]       RS_ID,
  input  logic [4:0]       RT_ID,
  input  logic             UsesRT_ID,
  input  logic             BranchTaken_EX,
  input  logic             DivStart_EX,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic             EXMEMBubble,
  output logic             DivBusy,
  output logic             DivDone,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic {RUN = 1'b0, DIV_WAIT = 1'b1} state_t;

  // First DIV_WAIT cycle loads this; the start cycle itself counts as one.
  localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [4:0] r_divcnt, w_divcnt_nxt;
  logic       w_loadhaz;

  // Load-use hazard; R0 never carries a real dependency.
  assign w_loadhaz = MemRead_EX && (RT_EX != 5'd0) &&
                     ((RT_EX == RS_ID) || (UsesRT_ID && (RT_EX == RT_ID)));

  // State and divide counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= RUN;
      r_divcnt <= 5'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_divcnt <= w_divcnt_nxt;
    end
  end

  // Next-state and control outputs; divide > branch > load-use.
  always_comb begin
    w_state_nxt  = r_state;
    w_divcnt_nxt = r_divcnt;
    PCWrite      = 1'b1;
    IFIDWrite    = 1'b1;
    IDEXWrite    = 1'b1;
    IFIDFlush    = 1'b0;
    IDEXBubble   = 1'b0;
    EXMEMBubble  = 1'b0;
    DivBusy      = 1'b0;
    DivDone      = 1'b0;
    case (r_state)
      RUN: begin
        if (DivStart_EX) begin
          PCWrite      = 1'b0;
          IFIDWrite    = 1'b0;
          IDEXWrite    = 1'b0;
          DivBusy      = 1'b1;
          w_state_nxt  = DIV_WAIT;
          w_divcnt_nxt = DIV_LOAD;
        end else if (BranchTaken_EX) begin
          IFIDFlush  = 1'b1;
          IDEXBubble = 1'b1;
        end else if (w_loadhaz) begin
          // Bubble pushes the load out of EX, so the stall self-clears.
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
        end
      end
      DIV_WAIT: begin
        PCWrite      = 1'b0;
        IFIDWrite    = 1'b0;
        IDEXWrite    = 1'b0;
        DivBusy      = 1'b1;
        w_divcnt_nxt = r_divcnt - 5'd1;
        if (r_divcnt == 5'd1) begin
          // Final cycle: the quotient moves on into EX/MEM.
          DivDone     = 1'b1;
          w_state_nxt = RUN;
        end else begin
          EXMEMBubble = 1'b1;
        end
      end
      default: begin
        w_state_nxt  = RUN;
        w_divcnt_nxt = 5'd0;
      end
    endcase
  end

  // Count frozen-PC cycles, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      StallCount <= '0;
    else if (!PCWrite && (StallCount != {CNT_W{1'b1}}))
      StallCount <= StallCount + 1'b1;
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: load-use, R0/RT-unused, branch
// priority, full divide, reset mid-divide and counter saturation.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead_EX, UsesRT_ID, BranchTaken_EX, DivStart_EX;
  logic [4:0]  RT_EX, RS_ID, RT_ID;
  logic        PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXBubble;
  logic        EXMEMBubble, DivBusy, DivDone;
  logic [15:0] StallCount;
  logic        s_PCWrite, s_IFIDWrite, s_IDEXWrite, s_IFIDFlush, s_IDEXBubble;
  logic        s_EXMEMBubble, s_DivBusy, s_DivDone;
  logic [3:0]  s_StallCount;
  logic [7:0]  outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.DIV_CYCLES(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .MemRead_EX(MemRead_EX), .RT_EX(RT_EX),
    .RS_ID(RS_ID), .RT_ID(RT_ID), .UsesRT_ID(UsesRT_ID),
    .BranchTaken_EX(BranchTaken_EX), .DivStart_EX(DivStart_EX),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
    .IFIDFlush(IFIDFlush), .IDEXBubble(IDEXBubble), .EXMEMBubble(EXMEMBubble),
    .DivBusy(DivBusy), .DivDone(DivDone), .StallCount(StallCount));

  hazard_stall_unit #(.DIV_CYCLES(8), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .MemRead_EX(MemRead_EX), .RT_EX(RT_EX),
    .RS_ID(RS_ID), .RT_ID(RT_ID), .UsesRT_ID(UsesRT_ID),
    .BranchTaken_EX(BranchTaken_EX), .DivStart_EX(DivStart_EX),
    .PCWrite(s_PCWrite), .IFIDWrite(s_IFIDWrite), .IDEXWrite(s_IDEXWrite),
    .IFIDFlush(s_IFIDFlush), .IDEXBubble(s_IDEXBubble),
    .EXMEMBubble(s_EXMEMBubble), .DivBusy(s_DivBusy), .DivDone(s_DivDone),
    .StallCount(s_StallCount));

  // {PCWrite,IFIDWrite,IDEXWrite,IFIDFlush,IDEXBubble,EXMEMBubble,DivBusy,DivDone}
  assign outs = {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush,
                 IDEXBubble, EXMEMBubble, DivBusy, DivDone};

  localparam logic [7:0] O_IDLE  = 8'b1110_0000;
  localparam logic [7:0] O_LOAD  = 8'b0010_1000;
  localparam logic [7:0] O_BR    = 8'b1111_1000;
  localparam logic [7:0] O_DSTRT = 8'b0000_0010;
  localparam logic [7:0] O_DWAIT = 8'b0000_0110;
  localparam logic [7:0] O_DLAST = 8'b0000_0011;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    MemRead_EX = 0; UsesRT_ID = 0; BranchTaken_EX = 0; DivStart_EX = 0;
    RT_EX = 0; RS_ID = 0; RT_ID = 0;
  endtask

  // Move to the next low phase; inputs change here, outputs settle by #1.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #2;
    chk("reset_outs", 32'(outs), 32'(O_IDLE));
    chk("reset_cnt", 32'(StallCount), 0);
    cyc(); cyc();
    reset = 1'b1;
    cyc(); #1;
    chk("idle_outs", 32'(outs), 32'(O_IDLE));

    // Load-use on RS
    cyc(); MemRead_EX = 1; RT_EX = 5'd5; RS_ID = 5'd5; #1;
    chk("loaduse_outs", 32'(outs), 32'(O_LOAD));
    cyc(); idle(); #1;
    chk("loaduse_clear", 32'(outs), 32'(O_IDLE));
    chk("loaduse_cnt", 32'(StallCount), 1);

    // R0 destination: no stall
    cyc(); MemRead_EX = 1; RT_EX = 5'd0; RS_ID = 5'd0; #1;
    chk("r0_nostall", 32'(outs), 32'(O_IDLE));
    // RT match but RT unused: no stall
    cyc(); MemRead_EX = 1; RT_EX = 5'd7; RS_ID = 5'd3; RT_ID = 5'd7; UsesRT_ID = 0; #1;
    chk("rtunused_nostall", 32'(outs), 32'(O_IDLE));
    // Same with RT used: stall
    UsesRT_ID = 1; #1;
    chk("rtused_stall", 32'(outs), 32'(O_LOAD));
    cyc(); idle(); #1;
    chk("rtused_cnt", 32'(StallCount), 2);

    // Branch beats load-use
    cyc(); MemRead_EX = 1; RT_EX = 5'd9; RS_ID = 5'd9; BranchTaken_EX = 1; #1;
    chk("prio_outs", 32'(outs), 32'(O_BR));
    cyc(); idle(); #1;
    chk("prio_cnt", 32'(StallCount), 2);

    // Full divide, 8 cycles; branch/loadhaz asserted during wait are ignored
    cyc(); DivStart_EX = 1; BranchTaken_EX = 1; #1;
    chk("div_c1", 32'(outs), 32'(O_DSTRT));
    for (int i = 2; i <= 8; i++) begin
      cyc(); idle(); BranchTaken_EX = 1; MemRead_EX = 1; RT_EX = 5'd4; RS_ID = 5'd4;
      DivStart_EX = (i == 3); #1;
      chk($sformatf("div_c%0d", i), 32'(outs), 32'((i == 8) ? O_DLAST : O_DWAIT));
    end
    cyc(); idle(); #1;
    chk("div_after", 32'(outs), 32'(O_IDLE));
    chk("div_cnt", 32'(StallCount), 10);

    // Reset during divide cycle 4
    cyc(); DivStart_EX = 1; #1;
    chk("rdiv_c1", 32'(outs), 32'(O_DSTRT));
    cyc(); idle(); cyc(); cyc(); #1;
    chk("rdiv_c4", 32'(outs), 32'(O_DWAIT));
    chk("rdiv_cnt_pre", 32'(StallCount), 13);
    #1 reset = 1'b0; #1;
    chk("rdiv_outs", 32'(outs), 32'(O_IDLE));
    chk("rdiv_cnt", 32'(StallCount), 0);
    cyc(); reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(); #1;
      chk($sformatf("rdiv_nodone%0d", i), 32'(outs), 32'(O_IDLE));
    end
    chk("rdiv_cnt_post", 32'(StallCount), 0);

    // 20 consecutive load-use stall cycles
    cyc(); MemRead_EX = 1; RT_EX = 5'd12; RT_ID = 5'd12; UsesRT_ID = 1; RS_ID = 5'd1;
    for (int i = 0; i < 20; i++) cyc();
    idle(); #1;
    chk("sat_cnt4", 32'(s_StallCount), 15);
    chk("sat_cnt16", 32'(StallCount), 20);
    cyc(); #1;
    chk("sat_hold", 32'(s_StallCount), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
